// File: rtl/seg_scan_if.sv
// ---------------------------------------------------------------------------
// seg_scan_if
// Update channel carrying a new display value into seg_scan_ctrl.
//
// Handshake: a transfer happens on a rising clk edge where upd_valid and
// upd_ready are both 1. The master holds upd_data/upd_dp stable while
// upd_valid is 1. The master may drop upd_valid without a transfer.
//
// Signals:
//   upd_valid  master -> slave  update request
//   upd_ready  slave -> master  controller can accept an update
//   upd_data   master -> slave  24-bit value, nibble k shown on digit k
//   upd_dp     master -> slave  decimal-point mask, bit k for digit k
// ---------------------------------------------------------------------------
interface seg_scan_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [23:0] upd_data;
  logic [5:0]  upd_dp;

  modport master (
    output upd_valid,
    output upd_data,
    output upd_dp,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_data,
    input  upd_dp,
    output upd_ready
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for a 6-digit common-anode seven-segment
// display. A new value arrives over the upd channel, waits in a pending
// register and is copied to the displayed (active) register only at a frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Each digit owns a slot of SCAN_DIV cycles. The first BLANK_CYC cycles of a
// slot are dark (BLANK) to suppress ghosting, the rest drive that digit
// (DRIVE). All display outputs are registered and lag the internal state by
// one cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           1 = scanning, 0 = display dark (pending update commits)
//   lz_en        1 = blank leading zero digits (digit 0 never blanked)
//   upd          update channel (slave side)
//   seg_n        active-low segments, bit0 = a .. bit6 = g
//   dp_n         active-low decimal point
//   dig_sel_n    active-low digit enables, at most one bit low
//   frame_tick   one-cycle pulse when digit 5's slot ends
//   drive_dbg    current scan state, 1 = DRIVE, 0 = BLANK
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        lz_en,
  seg_scan_if.slave   upd,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [5:0]  dig_sel_n,
  output logic        frame_tick,
  output logic        drive_dbg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;

  logic [23:0] act_data, pend_data;
  logic [5:0]  act_dp, pend_dp;
  logic        pend;
  logic        rdy;

  logic        slot_end, frame_end, capture, commit;
  logic [23:0] shifted;
  logic        lz_blank;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;
  logic [5:0]  dig_nxt;

  assign upd.upd_ready = rdy;
  assign drive_dbg     = (state == DRIVE);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    state_nxt = state;
    seg_nxt   = 7'h7F;
    dp_nxt    = 1'b1;
    dig_nxt   = 6'h3F;

    slot_end  = (cnt == CNT_MAX);
    frame_end = en && slot_end && (idx == 3'd5);
    capture   = upd.upd_valid && rdy;
    // rdy is low whenever pend is set, so capture and commit are exclusive.
    commit    = pend && (frame_end || !en);

    if (!en) begin
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (slot_end) begin
      cnt_nxt = '0;
      idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
    state_nxt = (cnt_nxt < BLANK_LIM) ? BLANK : DRIVE;

    // Nibbles idx..5 end up in the low bits; all zero means this digit and
    // every more significant one are zero.
    shifted  = act_data >> {idx, 2'b00};
    lz_blank = lz_en && (idx != 3'd0) && (shifted == 24'd0);

    if (en && state == DRIVE) begin
      dig_nxt = ~(6'b000001 << idx);
      seg_nxt = lz_blank ? 7'h7F : seg_decode(shifted[3:0]);
      dp_nxt  = ~act_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      dig_sel_n  <= 6'h3F;
      frame_tick <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend       <= 1'b0;
      rdy        <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      seg_n      <= seg_nxt;
      dp_n       <= dp_nxt;
      dig_sel_n  <= dig_nxt;
      frame_tick <= frame_end;
      if (capture) begin
        pend_data <= upd.upd_data;
        pend_dp   <= upd.upd_dp;
        pend      <= 1'b1;
        rdy       <= 1'b0;
      end else if (commit) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        pend      <= 1'b0;
        rdy       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Bench for seg_scan_ctrl with SCAN_DIV = 10, BLANK_CYC = 2. A small cycle
// model (phase counter plus displayed/pending data) predicts every output on
// every scan cycle; a table of digit vectors checks decode, leading-zero
// blanking and decimal points; hand-written sequences cover en drop and
// asynchronous reset.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int SD = 10;
  localparam int BC = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       lz_en;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] dig_sel_n;
  logic       frame_tick;
  logic       drive_dbg;

  seg_scan_if bus ();

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .lz_en      (lz_en),
    .upd        (bus.slave),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .dig_sel_n  (dig_sel_n),
    .frame_tick (frame_tick),
    .drive_dbg  (drive_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] dec [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // cycle model state
  int          ph;
  logic [23:0] m_data, m_pd;
  logic [5:0]  m_dp, m_pdp;
  bit          m_pend;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [23:0] data;
    logic [5:0]  dp;
    logic        lz;
    int          dig;
    logic [6:0]  seg;
    logic        dpn;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: load a value while en = 0; commits one cycle after capture
  task automatic load_en0(input logic [23:0] d, input logic [5:0] p);
    bus.upd_valid = 1'b1;
    bus.upd_data  = d;
    bus.upd_dp    = p;
    step();
    bus.upd_valid = 1'b0;
    chk("ready_low_after_capture", bus.upd_ready, 1'b0);
    step();
    chk("ready_high_after_commit", bus.upd_ready, 1'b1);
  endtask

  // one scan cycle with every output predicted by the model
  task automatic scan_step();
    bit          cap;
    int          c, i;
    logic [6:0]  es;
    logic        edp;
    logic [5:0]  ed;
    logic [23:0] up;
    cap = bus.upd_valid && !m_pend;
    step();
    ph++;
    c   = (ph - 1) % SD;
    i   = ((ph - 1) / SD) % 6;
    es  = 7'h7F;
    edp = 1'b1;
    ed  = 6'h3F;
    if (c >= BC) begin
      ed  = ~(6'b000001 << i);
      up  = m_data >> (4 * i);
      es  = (lz_en && i > 0 && up == 24'd0) ? 7'h7F : dec[up[3:0]];
      edp = ~m_dp[i];
    end
    chk("scan_dig_sel_n", dig_sel_n, ed);
    chk("scan_seg_n", seg_n, es);
    chk("scan_dp_n", dp_n, edp);
    chk("scan_frame_tick", frame_tick, (ph % (6 * SD) == 0));
    if ((ph % (6 * SD) == 0) && m_pend) begin
      m_data = m_pd;
      m_dp   = m_pdp;
      m_pend = 1'b0;
    end
    if (cap) begin
      m_pend = 1'b1;
      m_pd   = bus.upd_data;
      m_pdp  = bus.upd_dp;
    end
    chk("scan_upd_ready", bus.upd_ready, !m_pend);
  endtask

  task automatic model_restart(input logic [23:0] d, input logic [5:0] p);
    ph     = 0;
    m_data = d;
    m_dp   = p;
    m_pend = 1'b0;
  endtask

  task automatic wait_digit(input int k, output bit ok);
    logic [5:0] pat;
    pat = ~(6'b000001 << k);
    ok  = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      step();
      if (dig_sel_n == pat) ok = 1'b1;
    end
  endtask

  initial begin
    bit         ok;
    logic [7:0] got;
    logic [7:0] want;

    vecs[0]  = '{24'h000120, 6'h00, 1'b1, 5, 7'h7F, 1'b1};
    vecs[1]  = '{24'h000120, 6'h00, 1'b1, 4, 7'h7F, 1'b1};
    vecs[2]  = '{24'h000120, 6'h00, 1'b1, 3, 7'h7F, 1'b1};
    vecs[3]  = '{24'h000120, 6'h00, 1'b1, 2, 7'h79, 1'b1};
    vecs[4]  = '{24'h000120, 6'h00, 1'b1, 1, 7'h24, 1'b1};
    vecs[5]  = '{24'h000120, 6'h00, 1'b1, 0, 7'h40, 1'b1};
    vecs[6]  = '{24'h000000, 6'h00, 1'b1, 0, 7'h40, 1'b1};
    vecs[7]  = '{24'h000000, 6'h00, 1'b1, 3, 7'h7F, 1'b1};
    vecs[8]  = '{24'h000000, 6'h00, 1'b0, 3, 7'h40, 1'b1};
    vecs[9]  = '{24'h000120, 6'h04, 1'b1, 2, 7'h79, 1'b0};
    vecs[10] = '{24'h000120, 6'h04, 1'b1, 3, 7'h7F, 1'b1};
    vecs[11] = '{24'h000000, 6'h04, 1'b1, 2, 7'h7F, 1'b0};
    vecs[12] = '{24'h000000, 6'h04, 1'b1, 1, 7'h7F, 1'b1};
    vecs[13] = '{24'hABCDEF, 6'h00, 1'b0, 3, 7'h46, 1'b1};
    vecs[14] = '{24'hABCDEF, 6'h00, 1'b0, 2, 7'h21, 1'b1};
    vecs[15] = '{24'hABCDEF, 6'h00, 1'b0, 1, 7'h06, 1'b1};
    vecs[16] = '{24'h789000, 6'h00, 1'b1, 1, 7'h40, 1'b1};
    vecs[17] = '{24'h789000, 6'h00, 1'b1, 5, 7'h78, 1'b1};
    vecs[18] = '{24'h456789, 6'h3F, 1'b0, 4, 7'h12, 1'b0};
    vecs[19] = '{24'h456789, 6'h3F, 1'b0, 0, 7'h10, 1'b0};

    rst_n         = 1'b1;
    en            = 1'b0;
    lz_en         = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_data  = '0;
    bus.upd_dp    = '0;

    // reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_dig_sel_n", dig_sel_n, 6'h3F);
    chk("rst_frame_tick", frame_tick, 1'b0);
    chk("rst_upd_ready", bus.upd_ready, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: load 123456 while dark, then two full frames
    load_en0(24'h123456, 6'h00);
    en = 1'b1;
    model_restart(24'h123456, 6'h00);
    for (int n = 0; n < 120; n++) scan_step();

    // 2: mid-frame update while digit 2 is driven
    for (int n = 0; n < 23; n++) scan_step();
    bus.upd_valid = 1'b1;
    bus.upd_data  = 24'hABCDEF;
    bus.upd_dp    = 6'h00;
    scan_step();
    bus.upd_valid = 1'b0;
    for (int n = 0; n < 96; n++) scan_step();

    // 5: en drop mid-DRIVE with an update pending
    for (int n = 0; n < 5; n++) scan_step();
    bus.upd_valid = 1'b1;
    bus.upd_data  = 24'h000120;
    bus.upd_dp    = 6'h00;
    scan_step();
    bus.upd_valid = 1'b0;
    for (int n = 0; n < 18; n++) scan_step();
    chk("pre_drop_driving", dig_sel_n, 6'h3B);
    en = 1'b0;
    step();
    chk("drop_dig_sel_n", dig_sel_n, 6'h3F);
    chk("drop_seg_n", seg_n, 7'h7F);
    chk("drop_dp_n", dp_n, 1'b1);
    chk("drop_frame_tick", frame_tick, 1'b0);
    chk("drop_commit_ready", bus.upd_ready, 1'b1);
    step();
    chk("drop_still_dark", dig_sel_n, 6'h3F);
    en = 1'b1;
    model_restart(24'h000120, 6'h00);
    for (int n = 0; n < 15; n++) scan_step();

    // 3/4: decode, leading-zero blanking and decimal-point table
    for (int v = 0; v < 20; v++) begin
      en = 1'b0;
      step();
      load_en0(vecs[v].data, vecs[v].dp);
      lz_en = vecs[v].lz;
      en    = 1'b1;
      exp_q.push_back({vecs[v].seg, vecs[v].dpn});
      wait_digit(vecs[v].dig, ok);
      chk("vec_digit_reached", ok, 1'b1);
      want = exp_q.pop_front();
      got  = {seg_n, dp_n};
      if (ok) chk("vec_seg_dp", got, want);
    end

    // 6: asynchronous reset mid-slot discards a pending update
    en = 1'b0;
    lz_en = 1'b0;
    step();
    load_en0(24'h000000, 6'h00);
    en = 1'b1;
    for (int n = 0; n < 25; n++) step();
    bus.upd_valid = 1'b1;
    bus.upd_data  = 24'h111111;
    bus.upd_dp    = 6'h3F;
    step();
    bus.upd_valid = 1'b0;
    chk("pre_rst_pending", bus.upd_ready, 1'b0);
    step();
    step();
    chk("pre_rst_driving", dig_sel_n, 6'h3B);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg_n", seg_n, 7'h7F);
    chk("arst_dp_n", dp_n, 1'b1);
    chk("arst_dig_sel_n", dig_sel_n, 6'h3F);
    chk("arst_frame_tick", frame_tick, 1'b0);
    chk("arst_upd_ready", bus.upd_ready, 1'b1);
    step();
    chk("arst_hold_tick", frame_tick, 1'b0);
    step();
    rst_n = 1'b1;
    model_restart(24'h000000, 6'h00);
    for (int n = 0; n < 70; n++) scan_step();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard time limit as a safety net
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (compared %0d)", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 6-digit common-anode seven-segment display.
- Accepts a 24-bit hex value (6 nibbles) plus a decimal-point mask over a valid/ready handshake.
- Double-buffers the value so a displayed frame never tears.
- Drives one digit at a time with a ghost-suppression blanking gap between digits.
- Sits between the register/counter logic that produces display values and the shared segment/digit-select pins.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (1 ms at 50 MHz); must be > BLANK_CYC
BLANK_CYC, 500, cycles at the start of each slot with all digits off; must be >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = scanning active; 0 = display dark
lz_en  input  1  1 = leading-zero blanking enabled
upd_valid  input  1  update request
upd_ready  output  1  controller can accept an update
upd_data  input  24  nibble k (bits 4k+3:4k) shown on digit k; digit 5 is most significant
upd_dp  input  6  bit k = 1 lights the decimal point of digit k
seg_n  output  7  active-low segments; bit0 = a … bit6 = g
dp_n  output  1  active-low decimal point
dig_sel_n  output  6  active-low digit enables; at most one bit is 0
frame_tick  output  1  one-cycle pulse when digit 5's slot ends

Behaviour:
- Reset (async, rst_n = 0):
  - seg_n = 7'h7F, dp_n = 1, dig_sel_n = 6'h3F
  - upd_ready = 1, frame_tick = 0
  - active/pending data = 0, pending flag = 0
  - digit index = 0, slot counter = 0, state = BLANK
- All outputs are registered.
- States:
  - BLANK: dig_sel_n = 6'h3F, seg_n = 7'h7F, dp_n = 1.
  - DRIVE: dig_sel_n[idx] = 0, with segments/dp for digit idx.
- Slot timing:
  - Slot counter runs 0..SCAN_DIV-1.
  - BLANK while counter < BLANK_CYC; DRIVE otherwise.
  - At counter = SCAN_DIV-1: counter wraps to 0 and idx advances 0→1→…→5→0.
  - Frame length = 6*SCAN_DIV cycles.
  - DRIVE lasts exactly SCAN_DIV-BLANK_CYC cycles per digit.
- Outputs vs. state: outputs reflect the state of the previous cycle (1-cycle registered latency).
- Digit enable: never two digits enabled simultaneously, including across transitions.
- Decode (common anode) seg_n values:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E (low 7 bits)
- Leading-zero blanking (lz_en = 1):
  - Digit k (k ≥ 1) gets seg_n = 7'h7F when its nibble and all more-significant nibbles are 0.
  - Digit 0 is never blanked.
  - dp_n and dig_sel_n still follow normal rules for a blanked digit.
- Handshake:
  - Transfer occurs on a clk edge with upd_valid & upd_ready.
  - On transfer: upd_data/upd_dp are captured to the pending register, pending flag set, upd_ready = 0 from the next cycle.
  - Commit happens in the cycle where idx = 5 and counter = SCAN_DIV-1 (same cycle frame_tick is asserted on the following edge).
  - On commit: pending is copied to active, flag cleared, upd_ready returns to 1 the next cycle.
  - Latest-commit bound: a transfer is displayed no later than the start of the next frame.
  - Because upd_ready = 0 while pending, capture and commit never collide.
  - upd_valid may drop without a transfer; no state change results.
- en = 0:
  - Next cycle: outputs dark (as BLANK), counter = 0, idx = 0, state = BLANK, frame_tick = 0.
  - Any pending update commits immediately on that cycle.
  - Transfers while en = 0 commit on the cycle after capture (upd_ready low for exactly 1 cycle).
- en 0→1: scanning restarts at digit 0 with a full BLANK_CYC gap.
- Reset mid-frame: immediate return to reset values; pending update discarded.

Test Plan:
(Run with SCAN_DIV = 10, BLANK_CYC = 2.)
1. Reset then en = 1, transfer upd_data = 24'h123456, upd_dp = 0 while en = 0 → during frame: digit0 seg_n = 7'h02 (6), digit5 seg_n = 7'h79 (1); each dig_sel_n low for exactly 8 cycles, preceded by 2 dark cycles; frame_tick every 60 cycles.
2. Mid-frame transfer (idx = 2) of 24'hABCDEF → upd_ready low until commit; current frame still shows 123456; next frame shows digit0 = 7'h0E (F), digit5 = 7'h08 (A); upd_ready high the cycle after commit.
3. lz_en = 1, data 24'h000120 → digits 5,4,3 have seg_n = 7'h7F with dig_sel_n active; digit2 = 7'h79, digit1 = 7'h24, digit0 = 7'h40. Data 0 → only digit0 lit (7'h40).
4. upd_dp = 6'b000100 → dp_n = 0 only while dig_sel_n = 6'b111011, else 1; holds on a leading-zero-blanked digit.
5. Drop en mid-DRIVE with update pending → next cycle dig_sel_n = 6'h3F, seg_n = 7'h7F; pending committed, upd_ready = 1 next cycle; re-enable → first DRIVE on digit 0 after 2 dark cycles.
6. Assert rst_n = 0 mid-slot → all outputs at reset values asynchronously; no frame_tick; after release, digit0 shows 7'h40 (0).
